alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
- Downstream consumer of the clock block's 16-bit BCD HH:MM outputs (clock time and alarm time).
- Compares current time against the alarm setting and runs the ringing / snooze / stop state machine.
- Drives a gated buzzer tone and status LEDs.
- Sits between the clock block and the board buzzer/LED pins, alongside the display driver.

Parameters:
- RING_SEC, 60: seconds of ringing before auto-stop.
- SNOOZE_SEC, 300: seconds spent in snooze before re-ringing.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; further snooze presses are ignored.
- TONE_DIV, 50000: clk cycles per buzzer half-period.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- sec_tick  in  1  one-clk pulse once per second.
- alarm_en  in  1  alarm arm switch (level).
- clock_in  in  16  current time, BCD {H1,H0,M1,M0}.
- alarm_in  in  16  alarm time, same format.
- snooze  in  1  one-clk pulse from the debounced snooze button.
- stop  in  1  one-clk pulse from the debounced stop button.
- ringing  out  1  high in RINGING.
- buzzer  out  1  gated square wave.
- snooze_active  out  1  high in SNOOZE.
- snooze_cnt  out  2  snoozes used this event.
- armed_led  out  1  high in ARMED.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, tone divider 0, beep phase 0.
- match = (clock_in == alarm_in), a raw 16-bit compare. match_d is match registered; match_rise = match & ~match_d.
- States and transitions:
  - IDLE: alarm_en=1 -> ARMED next clk.
  - ARMED: match_rise -> RINGING. The ring timer loads RING_SEC, snooze_cnt=0, beep phase=1.
  - RINGING:
    - stop -> DONE.
    - else snooze and snooze_cnt<MAX_SNOOZE -> SNOOZE. The snooze timer loads SNOOZE_SEC, snooze_cnt+1.
    - else on sec_tick: ring timer decrements and beep phase toggles. When the timer reaches 0 on a tick -> DONE.
  - SNOOZE:
    - stop -> DONE.
    - else on sec_tick the snooze timer decrements. Reaching 0 -> RINGING, ring timer reloads RING_SEC, beep phase=1.
    - match_rise is ignored here.
  - DONE: match=0 -> ARMED. This prevents retriggering within the same minute.
- alarm_en=0 in any state -> IDLE next clk; timers cleared; snooze_cnt held until the next trigger.
- Priority in one cycle: alarm_en=0 > stop > snooze > sec_tick expiry.
- Snooze pressed at snooze_cnt==MAX_SNOOZE: ignored, ringing continues, ring timer is not reloaded.
- Timers are sized by $clog2 of the max parameter +1. The ring timer's decrement and its expiry check use the same tick.
- If alarm_in is edited while ARMED so that it equals clock_in, match_rise fires and the alarm triggers.
- Buzzer:
  - The tone divider free-runs only in RINGING and toggles tone every TONE_DIV clks.
  - buzzer = tone & beep_phase (1 s on / 1 s off).
  - Outside RINGING: buzzer=0 and the divider is held at 0.
- Latency: ringing asserts 1 clk after the cycle clock_in becomes equal to alarm_in; it deasserts 1 clk after stop.
- Outputs are registered (ringing, snooze_active, armed_led are state decodes of a registered state).
- Reset mid-ring: immediate return to the reset values above.

Optional Feature:
- Macro ALARM_SNOOZE_EN.
- Defined: SNOOZE state, snooze timer and snooze_cnt behave as above.
- Undefined:
  - SNOOZE state and snooze timer are not built.
  - The snooze input is ignored; RINGING exits only via stop, timeout or alarm_en=0.
  - snooze_active and snooze_cnt are tied 0.

Test Plan:
(Bench params: RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2, TONE_DIV=4, sec_tick every 20 clk.)
- Trigger: alarm_en=1, alarm_in=16'h1524, clock_in steps 16'h1523 -> 16'h1524 -> ringing=1 one clk later; buzzer toggles every 4 clk during on-phase seconds.
- Timeout: no buttons -> ringing falls after 4 ticks, state DONE; clock_in to 16'h1525 -> armed_led=1; returning to 16'h1524 triggers again.
- Snooze: snooze pulse while ringing -> snooze_active=1, snooze_cnt=1, buzzer=0; after 3 ticks ringing=1. A second snooze gives snooze_cnt=2; a third snooze is ignored and ringing stays 1.
- Stop/snooze same clk: both pulses together -> DONE, snooze_cnt unchanged, buzzer=0.
- Disarm and reset: alarm_en=0 while ringing -> IDLE next clk, all indicators 0. rst=1 mid-SNOOZE -> all outputs 0 asynchronously.
- Macro off (ALARM_SNOOZE_EN undefined): snooze pulse while ringing -> ringing stays 1, snooze_active=0, snooze_cnt=0.

Source files
------------

// File: rtl/alarm_ctrl.sv
// alarm_ctrl
// ----------
// Compares the current BCD time against the alarm setting and runs the
// arm / ring / snooze / stop state machine. While ringing, the buzzer
// carries a square tone gated by a 1 s on / 1 s off beep phase.
//
// Build option:
//   ALARM_SNOOZE_EN  defined   -> SNOOZE state, snooze timer and snooze
//                                 counter are built.
//                    undefined -> the snooze input is ignored, and
//                                 snooze_active and snooze_cnt are tied 0.
//
// Parameters:
//   RING_SEC    seconds of ringing before auto-stop
//   SNOOZE_SEC  seconds spent in snooze before re-ringing
//   MAX_SNOOZE  snoozes allowed per alarm event (at most 3)
//   TONE_DIV    clk cycles per buzzer half-period
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   sec_tick       one-clk pulse once per second
//   alarm_en       alarm arm switch (level)
//   clock_in       current time, BCD {H1,H0,M1,M0}
//   alarm_in       alarm time, BCD {H1,H0,M1,M0}
//   snooze         one-clk snooze button pulse
//   stop           one-clk stop button pulse
//   ringing        high while RINGING
//   buzzer         gated square-wave tone
//   snooze_active  high while SNOOZE
//   snooze_cnt     snoozes used in the current alarm event
//   armed_led      high while ARMED
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int TONE_DIV   = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sec_tick,
  input  logic        alarm_en,
  input  logic [15:0] clock_in,
  input  logic [15:0] alarm_in,
  input  logic        snooze,
  input  logic        stop,
  output logic        ringing,
  output logic        buzzer,
  output logic        snooze_active,
  output logic [1:0]  snooze_cnt,
  output logic        armed_led
);

  localparam int RW = $clog2(RING_SEC + 1);
  localparam int DW = $clog2(TONE_DIV + 1);

  localparam logic [RW-1:0] RING_LD  = RW'(RING_SEC);
  localparam logic [RW-1:0] RING_ONE = RW'(1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TONE_DIV - 1);

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_SEC + 1);

  localparam logic [SW-1:0] SNOOZE_LD  = SW'(SNOOZE_SEC);
  localparam logic [SW-1:0] SNOOZE_ONE = SW'(1);
  localparam logic [1:0]    MAX_SN     = 2'(MAX_SNOOZE);
`else
  localparam int unused_snooze_params = SNOOZE_SEC + MAX_SNOOZE;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RINGING = 3'd2,
    DONE    = 3'd3
`ifdef ALARM_SNOOZE_EN
    ,
    SNOOZE  = 3'd4
`endif
  } state_t;

  state_t          state;
  logic            match;
  logic            match_d;
  logic            match_rise;
  logic [RW-1:0]   ring_tmr;
  logic            beep_phase;
  logic            tone;
  logic [DW-1:0]   div_cnt;

`ifdef ALARM_SNOOZE_EN
  logic [SW-1:0]   snooze_tmr;
  logic [1:0]      snooze_cnt_q;
`else
  logic            unused_snooze_in;
  assign unused_snooze_in = snooze;
`endif

  // Raw compare; edge detection means a trigger happens once per
  // transition into equality, including alarm_in edits while armed.
  assign match      = (clock_in == alarm_in);
  assign match_rise = match & ~match_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_d <= 1'b0;
    end else begin
      match_d <= match;
    end
  end

  // Tone divider free-runs only while ringing; it restarts from zero on
  // every entry into RINGING.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tone    <= 1'b0;
    end else if (state == RINGING) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        tone    <= ~tone;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end else begin
      div_cnt <= '0;
      tone    <= 1'b0;
    end
  end

  // Main FSM. alarm_en=0 overrides everything; within RINGING the order
  // is stop, then snooze, then the per-second timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ring_tmr     <= '0;
      beep_phase   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_tmr   <= '0;
      snooze_cnt_q <= '0;
`endif
    end else if (!alarm_en) begin
      // snooze_cnt is intentionally held until the next trigger
      state      <= IDLE;
      ring_tmr   <= '0;
      beep_phase <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_tmr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= ARMED;
        end

        ARMED: begin
          if (match_rise) begin
            state        <= RINGING;
            ring_tmr     <= RING_LD;
            beep_phase   <= 1'b1;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q <= '0;
`endif
          end
        end

        RINGING: begin
          if (stop) begin
            state    <= DONE;
            ring_tmr <= '0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze && (snooze_cnt_q < MAX_SN)) begin
            state        <= SNOOZE;
            snooze_tmr   <= SNOOZE_LD;
            snooze_cnt_q <= snooze_cnt_q + 2'd1;
          end
`endif
          else if (sec_tick) begin
            // decrement and expiry share the same tick
            ring_tmr   <= ring_tmr - RING_ONE;
            beep_phase <= ~beep_phase;
            if (ring_tmr == RING_ONE) begin
              state <= DONE;
            end
          end
        end

`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop) begin
            state      <= DONE;
            snooze_tmr <= '0;
          end else if (sec_tick) begin
            snooze_tmr <= snooze_tmr - SNOOZE_ONE;
            if (snooze_tmr == SNOOZE_ONE) begin
              state      <= RINGING;
              ring_tmr   <= RING_LD;
              beep_phase <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          // stay here until the matching minute has passed
          if (!match) begin
            state <= ARMED;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ringing   = (state == RINGING);
  assign armed_led = (state == ARMED);
  assign buzzer    = tone & beep_phase & ringing;

`ifdef ALARM_SNOOZE_EN
  assign snooze_active = (state == SNOOZE);
  assign snooze_cnt    = snooze_cnt_q;
`else
  assign snooze_active = 1'b0;
  assign snooze_cnt    = '0;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

  localparam int RING_SEC   = 4;
  localparam int SNOOZE_SEC = 3;
  localparam int MAX_SNOOZE = 2;
  localparam int TONE_DIV   = 4;
  localparam int TICK_PER   = 20;

`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sec_tick = 1'b0;
  logic        alarm_en = 1'b0;
  logic [15:0] clock_in = '0;
  logic [15:0] alarm_in = '0;
  logic        snooze = 1'b0;
  logic        stop = 1'b0;
  logic        ringing;
  logic        buzzer;
  logic        snooze_active;
  logic [1:0]  snooze_cnt;
  logic        armed_led;

  alarm_ctrl #(
    .RING_SEC  (RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC),
    .MAX_SNOOZE(MAX_SNOOZE),
    .TONE_DIV  (TONE_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sec_tick     (sec_tick),
    .alarm_en     (alarm_en),
    .clock_in     (clock_in),
    .alarm_in     (alarm_in),
    .snooze       (snooze),
    .stop         (stop),
    .ringing      (ringing),
    .buzzer       (buzzer),
    .snooze_active(snooze_active),
    .snooze_cnt   (snooze_cnt),
    .armed_led    (armed_led)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int tick_ctr = 0;

  // Reference model: alarm behaviour expressed as seconds remaining,
  // snoozes used, and time elapsed since the ring started.
  typedef enum {M_IDLE, M_ARMED, M_RING, M_SNZ, M_DONE} mode_e;
  mode_e mode;
  bit    prev_match;
  int    ring_left;
  int    snz_left;
  int    snz_used;
  int    ring_cyc;    // clk edges spent ringing since this ring started
  int    ring_ticks;  // seconds elapsed since this ring started

  task automatic model_reset();
    mode       = M_IDLE;
    prev_match = 1'b0;
    ring_left  = 0;
    snz_left   = 0;
    snz_used   = 0;
    ring_cyc   = 0;
    ring_ticks = 0;
  endtask

  task automatic start_ring();
    mode       = M_RING;
    ring_left  = RING_SEC;
    ring_cyc   = 0;
    ring_ticks = 0;
  endtask

  task automatic model_step();
    bit m, rise;
    m          = (clock_in == alarm_in);
    rise       = m && !prev_match;
    prev_match = m;
    if (!alarm_en) begin
      mode = M_IDLE;
    end else begin
      case (mode)
        M_IDLE:  mode = M_ARMED;
        M_ARMED: if (rise) begin
          start_ring();
          snz_used = 0;
        end
        M_RING: begin
          ring_cyc++;
          if (stop) begin
            mode = M_DONE;
          end else if (SNZ_EN && snooze && snz_used < MAX_SNOOZE) begin
            mode     = M_SNZ;
            snz_left = SNOOZE_SEC;
            snz_used++;
          end else if (sec_tick) begin
            ring_ticks++;
            ring_left--;
            if (ring_left == 0) mode = M_DONE;
          end
        end
        M_SNZ: begin
          if (stop) begin
            mode = M_DONE;
          end else if (sec_tick) begin
            snz_left--;
            if (snz_left == 0) start_ring();
          end
        end
        M_DONE:  if (!m) mode = M_ARMED;
        default: mode = M_IDLE;
      endcase
    end
  endtask

  task automatic check();
    bit       e_ring, e_buz, e_snz, e_arm;
    bit [1:0] e_cnt;
    e_ring = (mode == M_RING);
    e_buz  = e_ring && (((ring_cyc / TONE_DIV) % 2) == 1) && ((ring_ticks % 2) == 0);
    e_snz  = (mode == M_SNZ);
    e_arm  = (mode == M_ARMED);
    e_cnt  = 2'(snz_used);

    n_cmp++;
    assert (ringing === e_ring) else begin
      n_fail++;
      $error("FAIL ringing got=%b exp=%b t=%0t", ringing, e_ring, $time);
    end
    n_cmp++;
    assert (buzzer === e_buz) else begin
      n_fail++;
      $error("FAIL buzzer got=%b exp=%b t=%0t", buzzer, e_buz, $time);
    end
    n_cmp++;
    assert (snooze_active === e_snz) else begin
      n_fail++;
      $error("FAIL snooze_active got=%b exp=%b t=%0t", snooze_active, e_snz, $time);
    end
    n_cmp++;
    assert (snooze_cnt === e_cnt) else begin
      n_fail++;
      $error("FAIL snooze_cnt got=%0d exp=%0d t=%0t", snooze_cnt, e_cnt, $time);
    end
    n_cmp++;
    assert (armed_led === e_arm) else begin
      n_fail++;
      $error("FAIL armed_led got=%b exp=%b t=%0t", armed_led, e_arm, $time);
    end
  endtask

  // One clock: drive the tick, step the model at the edge, check #1 later,
  // then drop the one-cycle pulses on the falling edge.
  task automatic cyc();
    sec_tick = (tick_ctr == TICK_PER - 1);
    tick_ctr = (tick_ctr + 1) % TICK_PER;
    @(posedge clk);
    model_step();
    #1 check();
    @(negedge clk);
    sec_tick = 1'b0;
    snooze   = 1'b0;
    stop     = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must clear without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] pick_time();
    case ($urandom_range(2))
      0:       return 16'h1523;
      1:       return 16'h1524;
      default: return 16'h1525;
    endcase
  endfunction

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1 check();
    @(negedge clk);
    rst = 1'b0;

    // arm, then trigger on 15:23 -> 15:24
    alarm_en = 1'b1;
    alarm_in = 16'h1524;
    clock_in = 16'h1523;
    run(3);
    clock_in = 16'h1524;
    run(1);

    // timeout with no buttons, re-arm on the next minute, retrigger
    run(100);
    clock_in = 16'h1525;
    run(2);
    clock_in = 16'h1524;
    run(30);

    // three snoozes in turn; the third exceeds the allowance
    snooze = 1'b1;
    run(1);
    run(70);
    snooze = 1'b1;
    run(1);
    run(70);
    snooze = 1'b1;
    run(1);
    run(5);

    // fresh trigger, then stop and snooze together
    clock_in = 16'h1525;
    run(100);
    clock_in = 16'h1524;
    run(10);
    snooze = 1'b1;
    stop   = 1'b1;
    run(1);
    run(3);

    // disarm while ringing
    clock_in = 16'h1525;
    run(2);
    clock_in = 16'h1524;
    run(5);
    alarm_en = 1'b0;
    run(3);

    // alarm_in edited to equal clock_in while armed
    alarm_en = 1'b1;
    clock_in = 16'h1530;
    alarm_in = 16'h1524;
    run(3);
    alarm_in = 16'h1530;
    run(6);

    // reset during snooze (or ringing when snooze is not built)
    snooze = 1'b1;
    run(1);
    run(8);
    do_reset();
    alarm_en = 1'b1;
    alarm_in = 16'h1524;
    clock_in = 16'h1523;
    run(3);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(29) == 0) clock_in = pick_time();
      if ($urandom_range(199) == 0) alarm_in = clock_in;
      if ($urandom_range(24) == 0) snooze = 1'b1;
      if ($urandom_range(79) == 0) stop = 1'b1;
      if (alarm_en && $urandom_range(299) == 0) alarm_en = 1'b0;
      else if (!alarm_en && $urandom_range(9) == 0) alarm_en = 1'b1;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
